r_response_arbiter: RTL and testbench

Round-robin arbiter that merges AXI R-beat streams from NUM_SRC upstream response sources into the single R path feeding outgoing_response_buffer. A grant is locked for the whole burst, from the first beat through the beat with last=1, so beats of different bursts are never interleaved at the buffer input. Beats pass combinationally with zero latency. A per-burst beat counter flags bursts that exceed the AXI maximum length.

---
 rtl/rob_pkg.sv | 41 ++++
 rtl/r_if.sv | 22 ++
 rtl/rr_pick.sv | 55 +++++
 rtl/r_response_arbiter.sv | 165 ++++++++++++++++
 tb/tb_r_response_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// ---------------------------------------------------------------------------
// rob_pkg
// Shared definitions for the read-response path: the R beat record that the
// arbiter hands to outgoing_response_buffer, the arbiter state encoding, the
// AXI burst-length limit and a small modular-add helper used for round-robin
// index arithmetic.
// No ports (package).
// ---------------------------------------------------------------------------
package rob_pkg;

    // AXI4 INCR bursts carry at most 256 beats.
    localparam int AXI_MAX_BEATS = 256;

    // Default field widths of one R beat as seen by the response buffer.
    localparam int BEAT_ID_WIDTH   = 4;
    localparam int BEAT_DATA_WIDTH = 64;
    localparam int BEAT_RESP_WIDTH = 2;

    typedef struct packed {
        logic [BEAT_ID_WIDTH-1:0]   id;
        logic [BEAT_DATA_WIDTH-1:0] data;
        logic [BEAT_RESP_WIDTH-1:0] resp;
        logic                       last;
    } r_beat_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // (a + b) mod n, valid when both a and b are already below n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/r_if.sv
// ---------------------------------------------------------------------------
// r_if
// One AXI R channel (valid/ready handshake plus id, data, resp, last).
// Modports:
//   sender   - drives valid and payload, observes ready
//   receiver - observes valid and payload, drives ready
// ---------------------------------------------------------------------------
interface r_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;

    modport sender   (output valid, id, data, resp, last, input  ready);
    modport receiver (input  valid, id, data, resp, last, output ready);
endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: rotates the request vector so that
// position 'ptr' becomes bit 0, takes the lowest set bit, then rotates the
// winning position back into source numbering.
// Ports:
//   req      in   NUM_SRC          request per source
//   ptr      in   $clog2(NUM_SRC)  highest-priority source
//   gnt_idx  out  $clog2(NUM_SRC)  winning source (0 when gnt_any=0)
//   gnt_any  out  1                at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import rob_pkg::*;
#(
    parameter int NUM_SRC = 4,
    localparam int PW     = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [PW-1:0]      gnt_idx,
    output logic               gnt_any
);

    logic [NUM_SRC-1:0] rot;
    logic [PW-1:0]      enc;
    logic [PW-1:0]      src_pos;
    logic               found;

    // Rotate so that rot[k] is the request of source (ptr + k) mod NUM_SRC;
    // the first set bit of rot is then the round-robin winner.
    always_comb begin
        rot     = '0;
        src_pos = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_pos = PW'(wrap_add(i, int'(ptr), NUM_SRC));
            rot[i]  = req[src_pos];
        end
    end

    // Lowest-index priority encode of the rotated vector, then undo the
    // rotation to recover the real source number.
    always_comb begin
        enc   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rot[i] & ~found) begin
                enc   = PW'(i);
                found = 1'b1;
            end
        end
        gnt_any = found;
        gnt_idx = found ? PW'(wrap_add(int'(enc), int'(ptr), NUM_SRC)) : '0;
    end

endmodule

// File: rtl/r_response_arbiter.sv
// ---------------------------------------------------------------------------
// r_response_arbiter
// Merges the R-beat streams of NUM_SRC response sources into the single R
// path feeding outgoing_response_buffer. Arbitration is round-robin, and a
// grant is held from the first beat of a burst through its last beat so that
// bursts never interleave. Beats pass through with zero latency. A per-burst
// beat counter raises len_err when a burst runs past MAX_BEATS beats.
// Ports:
//   clk        in   1                    rising-edge clock
//   rst        in   1                    synchronous active-high reset
//   src_valid  in   NUM_SRC              per-source R valid
//   src_ready  out  NUM_SRC              per-source R ready
//   src_id     in   NUM_SRC*ID_WIDTH     packed ids, source i in slice i
//   src_data   in   NUM_SRC*DATA_WIDTH   packed data
//   src_resp   in   NUM_SRC*RESP_WIDTH   packed resp
//   src_last   in   NUM_SRC              per-source last
//   r_out      r_if.sender               merged R stream
//   grant      out  NUM_SRC              one-hot driving source, 0 if none
//   busy       out  1                    burst lock held
//   len_err    out  1                    one-cycle pulse on over-long burst
// ---------------------------------------------------------------------------
module r_response_arbiter
    import rob_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int MAX_BEATS  = AXI_MAX_BEATS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC*ID_WIDTH-1:0]    src_id,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data,
    input  logic [NUM_SRC*RESP_WIDTH-1:0]  src_resp,
    input  logic [NUM_SRC-1:0]             src_last,
    r_if.sender                            r_out,
    output logic [NUM_SRC-1:0]             grant,
    output logic                           busy,
    output logic                           len_err
);

    localparam int PW = $clog2(NUM_SRC);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BEATS);
    localparam logic [CW-1:0] CNT_WARN = CW'(MAX_BEATS - 1);

    arb_state_e      state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   lock_idx;
    logic [CW-1:0]   beat_cnt;

    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic [PW-1:0]   sel_idx;
    logic            have_sel;
    logic [PW-1:0]   next_ptr;

    logic                  out_valid;
    logic [ID_WIDTH-1:0]   out_id;
    logic [DATA_WIDTH-1:0] out_data;
    logic [RESP_WIDTH-1:0] out_resp;
    logic                  out_last;
    logic                  fire;

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req     (src_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // While locked only the owner of the burst is eligible, and it stays
    // granted even across cycles where it has nothing valid to offer.
    always_comb begin
        sel_idx  = (state == BURST) ? lock_idx : pick_idx;
        have_sel = (state == BURST) | pick_any;
        next_ptr = PW'(wrap_add(int'(sel_idx), 1, NUM_SRC));
    end

    // Output mux built as an AND-OR over the one-hot grant, which also
    // forces the payload to zero whenever nobody is selected.
    always_comb begin
        grant     = '0;
        out_valid = 1'b0;
        out_id    = '0;
        out_data  = '0;
        out_resp  = '0;
        out_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            grant[i]  = have_sel & (sel_idx == PW'(i));
            out_valid = out_valid | (grant[i] & src_valid[i]);
            out_id    = out_id   | (src_id[i*ID_WIDTH +: ID_WIDTH]       & {ID_WIDTH{grant[i]}});
            out_data  = out_data | (src_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
            out_resp  = out_resp | (src_resp[i*RESP_WIDTH +: RESP_WIDTH] & {RESP_WIDTH{grant[i]}});
            out_last  = out_last | (src_last[i] & grant[i]);
        end
    end

    assign r_out.valid = out_valid;
    assign r_out.id    = out_id;
    assign r_out.data  = out_data;
    assign r_out.resp  = out_resp;
    assign r_out.last  = out_last;

    assign src_ready = grant & {NUM_SRC{r_out.ready}};
    assign fire      = out_valid & r_out.ready;

    // Burst-lock FSM. The round-robin pointer only moves when a burst
    // completes, so a source that was offered but not accepted keeps its
    // turn. The beat counter saturates rather than wrapping so an over-long
    // burst reports len_err once and the lock still waits for last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        if (out_last) begin
                            rr_ptr <= next_ptr;
                        end else begin
                            state    <= BURST;
                            busy     <= 1'b1;
                            lock_idx <= sel_idx;
                            beat_cnt <= CW'(1);
                        end
                    end
                end
                BURST: begin
                    if (fire) begin
                        if (out_last) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            rr_ptr   <= next_ptr;
                            beat_cnt <= '0;
                        end else begin
                            if (beat_cnt == CNT_WARN) begin
                                len_err <= 1'b1;
                            end
                            if (beat_cnt != CNT_MAX) begin
                                beat_cnt <= beat_cnt + CW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r_response_arbiter.sv
// ---------------------------------------------------------------------------
// tb_r_response_arbiter
// Directed bench for r_response_arbiter with NUM_SRC=4 and MAX_BEATS=8 so the
// over-length case stays short. Inputs change 1 time unit after a rising edge
// and outputs are sampled before the next rising edge.
// ---------------------------------------------------------------------------
module tb_r_response_arbiter;
    import rob_pkg::*;

    localparam int NS = 4;
    localparam int IW = 4;
    localparam int DW = 64;
    localparam int RW = 2;
    localparam int MB = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*IW-1:0]  src_id;
    logic [NS*DW-1:0]  src_data;
    logic [NS*RW-1:0]  src_resp;
    logic [NS-1:0]     src_last;
    logic [NS-1:0]     grant;
    logic              busy;
    logic              len_err;

    int n_checks = 0;
    int n_fail   = 0;

    r_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) r_bus ();

    r_response_arbiter #(
        .NUM_SRC    (NS),
        .ID_WIDTH   (IW),
        .DATA_WIDTH (DW),
        .RESP_WIDTH (RW),
        .MAX_BEATS  (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_id    (src_id),
        .src_data  (src_data),
        .src_resp  (src_resp),
        .src_last  (src_last),
        .r_out     (r_bus),
        .grant     (grant),
        .busy      (busy),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    // Source s presents one beat; id and resp are tied to the source number.
    task automatic set_beat(input int s, input logic v, input logic [DW-1:0] d, input logic l);
        src_valid[s]           = v;
        src_id[s*IW +: IW]     = IW'(s);
        src_data[s*DW +: DW]   = d;
        src_resp[s*RW +: RW]   = RW'(s);
        src_last[s]            = l;
    endtask

    task automatic clear_all();
        src_valid = '0;
        src_id    = '0;
        src_data  = '0;
        src_resp  = '0;
        src_last  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        r_bus.ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (grant !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
        n_checks++;
        if (src_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_src_ready: got %b expected 0000", src_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (len_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_len_err: got %b expected 0", len_err); end
        n_checks++;
        if (r_bus.valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", r_bus.valid); end
        n_checks++;
        if (dut.rr_ptr !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr); end
        n_checks++;
        if (dut.state !== IDLE) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected 0", dut.state); end
        n_checks++;
        if (dut.beat_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_beat_cnt: got %0d expected 0", dut.beat_cnt); end
        rst = 1'b0;
    endtask

    // Sources 0 and 2 each offer a single-beat burst.
    task automatic test_single_beat();
        set_beat(0, 1'b1, 64'h0000_00A0, 1'b1);
        set_beat(2, 1'b1, 64'h0000_00A2, 1'b1);
        #1;
        n_checks++;
        if (grant !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_grant0: got %b expected 0001", grant); end
        n_checks++;
        if (r_bus.data !== 64'h0000_00A0) begin n_fail++; $display("[TB] FAIL single_data0: got %h expected a0", r_bus.data); end
        n_checks++;
        if (src_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_ready0: got %b expected 0001", src_ready); end
        tick();
        set_beat(0, 1'b0, 64'h0, 1'b0);
        #1;
        n_checks++;
        if (dut.rr_ptr !== 2'd1) begin n_fail++; $display("[TB] FAIL single_ptr1: got %0d expected 1", dut.rr_ptr); end
        n_checks++;
        if (grant !== 4'b0100) begin n_fail++; $display("[TB] FAIL single_grant2: got %b expected 0100", grant); end
        n_checks++;
        if (r_bus.data !== 64'h0000_00A2) begin n_fail++; $display("[TB] FAIL single_data2: got %h expected a2", r_bus.data); end
        tick();
        set_beat(2, 1'b0, 64'h0, 1'b0);
        #1;
        n_checks++;
        if (dut.rr_ptr !== 2'd3) begin n_fail++; $display("[TB] FAIL single_ptr3: got %0d expected 3", dut.rr_ptr); end
        n_checks++;
        if (grant !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_idle_grant: got %b expected 0000", grant); end
        n_checks++;
        if ({r_bus.valid, r_bus.id, r_bus.data, r_bus.last} !== '0) begin
            n_fail++; $display("[TB] FAIL single_idle_payload: got v=%b id=%h d=%h l=%b expected all zero",
                               r_bus.valid, r_bus.id, r_bus.data, r_bus.last);
        end
    endtask

    // Source 1 sends 4 beats while source 3 waits with a valid beat.
    task automatic test_lock();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_beat(3, 1'b1, 64'h3333, 1'b1);
        for (int b = 0; b < 4; b++) begin
            set_beat(1, 1'b1, 64'h1100 + 64'(b), (b == 3));
            #1;
            n_checks++;
            if (grant !== 4'b0010) begin n_fail++; $display("[TB] FAIL lock_grant beat %0d: got %b expected 0010", b, grant); end
            n_checks++;
            if (src_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL lock_ready beat %0d: got %b expected 0010", b, src_ready); end
            n_checks++;
            if (r_bus.data !== 64'h1100 + 64'(b)) begin n_fail++; $display("[TB] FAIL lock_data beat %0d: got %h expected %h", b, r_bus.data, 64'h1100 + 64'(b)); end
            tick();
            if (b < 3) begin
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL lock_busy beat %0d: got %b expected 1", b, busy); end
            end
        end
        set_beat(1, 1'b0, 64'h0, 1'b0);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_release_busy: got %b expected 0", busy); end
        n_checks++;
        if (dut.rr_ptr !== 2'd2) begin n_fail++; $display("[TB] FAIL lock_release_ptr: got %0d expected 2", dut.rr_ptr); end
        n_checks++;
        if (grant !== 4'b1000) begin n_fail++; $display("[TB] FAIL lock_next_grant: got %b expected 1000", grant); end
        n_checks++;
        if (r_bus.data !== 64'h3333) begin n_fail++; $display("[TB] FAIL lock_next_data: got %h expected 3333", r_bus.data); end
        tick();
        set_beat(3, 1'b0, 64'h0, 1'b0);
        #1;
        n_checks++;
        if (dut.rr_ptr !== 2'd0) begin n_fail++; $display("[TB] FAIL lock_wrap_ptr: got %0d expected 0", dut.rr_ptr); end
    endtask

    // Buffer full for 5 cycles in the middle of a 3-beat burst from source 0.
    task automatic test_stall();
        set_beat(0, 1'b1, 64'h0A01, 1'b0);
        tick();
        set_beat(0, 1'b1, 64'h0A02, 1'b0);
        r_bus.ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_busy cyc %0d: got %b expected 1", c, busy); end
            n_checks++;
            if (dut.beat_cnt !== 4'd1) begin n_fail++; $display("[TB] FAIL stall_cnt cyc %0d: got %0d expected 1", c, dut.beat_cnt); end
            n_checks++;
            if ({r_bus.valid, r_bus.id, r_bus.data} !== {1'b1, 4'd0, 64'h0A02}) begin
                n_fail++; $display("[TB] FAIL stall_payload cyc %0d: got v=%b id=%h d=%h expected v=1 id=0 d=0a02", c, r_bus.valid, r_bus.id, r_bus.data);
            end
            n_checks++;
            if (src_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL stall_ready cyc %0d: got %b expected 0000", c, src_ready); end
            tick();
        end
        r_bus.ready = 1'b1;
        #1;
        n_checks++;
        if (src_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL stall_resume_ready: got %b expected 0001", src_ready); end
        tick();
        n_checks++;
        if (dut.beat_cnt !== 4'd2) begin n_fail++; $display("[TB] FAIL stall_resume_cnt: got %0d expected 2", dut.beat_cnt); end
        set_beat(0, 1'b1, 64'h0A03, 1'b1);
        tick();
        set_beat(0, 1'b0, 64'h0, 1'b0);
        #1;
        n_checks++;
        if ({busy, dut.rr_ptr, dut.beat_cnt} !== {1'b0, 2'd1, 4'd0}) begin
            n_fail++; $display("[TB] FAIL stall_end: got busy=%b ptr=%0d cnt=%0d expected busy=0 ptr=1 cnt=0", busy, dut.rr_ptr, dut.beat_cnt);
        end
    endtask

    // Over-long bursts: 9 beats from source 1, then 10 beats from source 2.
    task automatic test_len_err();
        for (int t = 0; t < 2; t++) begin
            int s;
            int nb;
            int pulses;
            int exp_cnt;
            s      = 1 + t;
            nb     = 9 + t;
            pulses = 0;
            for (int k = 1; k <= nb; k++) begin
                set_beat(s, 1'b1, (64'(s) << 16) | 64'(k), (k == nb));
                #1;
                n_checks++;
                if (grant !== 4'(1 << s)) begin n_fail++; $display("[TB] FAIL len_grant src %0d beat %0d: got %b expected %b", s, k, grant, 4'(1 << s)); end
                tick();
                n_checks++;
                if (len_err !== (k == MB)) begin n_fail++; $display("[TB] FAIL len_err src %0d beat %0d: got %b expected %b", s, k, len_err, (k == MB)); end
                exp_cnt = (k == nb) ? 0 : ((k < MB) ? k : MB);
                n_checks++;
                if (dut.beat_cnt !== 4'(exp_cnt)) begin n_fail++; $display("[TB] FAIL len_cnt src %0d beat %0d: got %0d expected %0d", s, k, dut.beat_cnt, exp_cnt); end
                if (len_err === 1'b1) pulses++;
            end
            set_beat(s, 1'b0, 64'h0, 1'b0);
            n_checks++;
            if (pulses !== 1) begin n_fail++; $display("[TB] FAIL len_pulses src %0d: got %0d expected 1", s, pulses); end
            n_checks++;
            if (dut.rr_ptr !== 2'(s + 1)) begin n_fail++; $display("[TB] FAIL len_ptr src %0d: got %0d expected %0d", s, dut.rr_ptr, s + 1); end
        end
    endtask

    // Reset lands on the edge where beat 2 of a source 3 burst would fire.
    task automatic test_reset_mid();
        set_beat(3, 1'b1, 64'h0031, 1'b0);
        tick();
        set_beat(3, 1'b1, 64'h0032, 1'b0);
        #1;
        n_checks++;
        if ({busy, grant} !== {1'b1, 4'b1000}) begin n_fail++; $display("[TB] FAIL mid_pre: got busy=%b grant=%b expected busy=1 grant=1000", busy, grant); end
        rst = 1'b1;
        tick();
        clear_all();
        #1;
        n_checks++;
        if (dut.state !== IDLE) begin n_fail++; $display("[TB] FAIL mid_state: got %0d expected 0", dut.state); end
        n_checks++;
        if (dut.rr_ptr !== 2'd0) begin n_fail++; $display("[TB] FAIL mid_ptr: got %0d expected 0", dut.rr_ptr); end
        n_checks++;
        if ({grant, src_ready} !== 8'h00) begin n_fail++; $display("[TB] FAIL mid_grant_ready: got grant=%b ready=%b expected 0000 0000", grant, src_ready); end
        n_checks++;
        if ({busy, dut.beat_cnt} !== 5'd0) begin n_fail++; $display("[TB] FAIL mid_busy_cnt: got busy=%b cnt=%0d expected 0 0", busy, dut.beat_cnt); end
        rst = 1'b0;
    endtask

    // All four sources always valid with 2-beat bursts, 16 bursts in total.
    task automatic test_back_to_back();
        r_beat_t exp_q[$];
        r_beat_t exp_b;
        r_beat_t obs_b;
        int beat_no[NS];
        int burst_no[NS];
        logic [NS-1:0] fired;
        for (int n = 0; n < 16; n++) begin
            for (int b = 0; b < 2; b++) begin
                exp_b.id   = 4'(n % 4);
                exp_b.data = (64'(n % 4) << 32) | (64'(n / 4) << 8) | 64'(b);
                exp_b.resp = 2'(n % 4);
                exp_b.last = (b == 1);
                exp_q.push_back(exp_b);
            end
        end
        for (int i = 0; i < NS; i++) begin
            beat_no[i]  = 0;
            burst_no[i] = 0;
        end
        r_bus.ready = 1'b1;
        for (int c = 0; c < 32; c++) begin
            for (int i = 0; i < NS; i++) begin
                set_beat(i, 1'b1, (64'(i) << 32) | (64'(burst_no[i]) << 8) | 64'(beat_no[i]), (beat_no[i] == 1));
            end
            #1;
            exp_b = exp_q.pop_front();
            obs_b = '{id: r_bus.id, data: r_bus.data, resp: r_bus.resp, last: r_bus.last};
            n_checks++;
            if (grant !== 4'(1 << exp_b.id)) begin n_fail++; $display("[TB] FAIL b2b_grant cyc %0d: got %b expected %b", c, grant, 4'(1 << exp_b.id)); end
            n_checks++;
            if ({r_bus.valid, obs_b} !== {1'b1, exp_b}) begin
                n_fail++; $display("[TB] FAIL b2b_beat cyc %0d: got v=%b %h expected v=1 %h", c, r_bus.valid, obs_b, exp_b);
            end
            fired = src_ready & src_valid;
            tick();
            for (int i = 0; i < NS; i++) begin
                if (fired[i]) begin
                    if (beat_no[i] == 1) begin
                        beat_no[i] = 0;
                        burst_no[i]++;
                    end else begin
                        beat_no[i] = 1;
                    end
                end
            end
        end
        clear_all();
        for (int i = 0; i < NS; i++) begin
            n_checks++;
            if (burst_no[i] !== 4) begin n_fail++; $display("[TB] FAIL b2b_bursts src %0d: got %0d expected 4", i, burst_no[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        r_bus.ready = 1'b1;
        clear_all();
        test_reset();
        test_single_beat();
        test_lock();
        test_stall();
        test_len_err();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule
